// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and byte-wide data accesses.
// A single transaction is in flight at a time, and a streak of data grants is capped so that fetch is not starved.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_cancel,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [7:0]  d_wdata,
  output logic        d_ready,
  output logic [7:0]  d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall_fetch,
  output logic        stall_data
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          drop_q, drop_d;
  logic [1:0]    lane_q, lane_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          if_ready_q, if_ready_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic          d_ready_q, d_ready_d;
  logic [7:0]    d_rdata_q, d_rdata_d;
  logic          grant_data, grant_fetch;
  logic [7:0]    load_byte;

  // Data normally wins, except when fetch has waited through STARVE_LIMIT data grants.
  assign grant_data  = (state_q == IDLE) && d_req &&
                       !(if_req && !if_cancel && (starve_q == LIMIT));
  assign grant_fetch = (state_q == IDLE) && !grant_data && if_req && !if_cancel;

  always_comb begin
    load_byte = mem_rdata[7:0];
    case (lane_q)
      2'd1:    load_byte = mem_rdata[15:8];
      2'd2:    load_byte = mem_rdata[23:16];
      2'd3:    load_byte = mem_rdata[31:24];
      default: load_byte = mem_rdata[7:0];
    endcase
  end

  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    lane_d      = lane_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    if_ready_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_ready_d   = 1'b0;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_data) begin
          state_d     = DATA;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = {d_addr[31:2], 2'b00};
          mem_be_d    = 4'b0001 << d_addr[1:0];
          mem_wdata_d = {4{d_wdata}};
          lane_d      = d_addr[1:0];
        end else if (grant_fetch) begin
          state_d     = FETCH;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = {if_addr[31:2], 2'b00};
          mem_be_d    = 4'hF;
          mem_wdata_d = 32'h0;
          drop_d      = 1'b0;
        end
      end
      FETCH: begin
        if (mem_ready) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          drop_d    = 1'b0;
          // A flush in the completion cycle itself also discards the word.
          if (!(drop_q || if_cancel)) begin
            if_ready_d = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else if (if_cancel) begin
          drop_d = 1'b1;
        end
      end
      DATA: begin
        if (mem_ready) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          d_ready_d = 1'b1;
          if (!mem_we_q) d_rdata_d = load_byte;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (!if_req || grant_fetch) starve_d = '0;
    else if (grant_data && (starve_q != LIMIT)) starve_d = starve_q + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      drop_q      <= 1'b0;
      lane_q      <= 2'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_be_q    <= 4'h0;
      mem_wdata_q <= 32'h0;
      if_ready_q  <= 1'b0;
      if_rdata_q  <= 32'h0;
      d_ready_q   <= 1'b0;
      d_rdata_q   <= 8'h0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      drop_q      <= drop_d;
      lane_q      <= lane_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      if_ready_q  <= if_ready_d;
      if_rdata_q  <= if_rdata_d;
      d_ready_q   <= d_ready_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_be      = mem_be_q;
  assign mem_wdata   = mem_wdata_q;
  assign if_ready    = if_ready_q;
  assign if_rdata    = if_rdata_q;
  assign d_ready     = d_ready_q;
  assign d_rdata     = d_rdata_q;
  assign stall_fetch = if_req & ~if_ready_q & ~if_cancel;
  assign stall_data  = d_req & ~d_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: single-transaction vectors from a table, then arbitration, cancel, idle and reset sequences.
// Ready pulses are checked against a queue of expected completions.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_cancel, d_req, d_we, mem_ready;
  logic [31:0] if_addr, d_addr, mem_rdata;
  logic [7:0]  d_wdata;
  logic        if_ready, d_ready, mem_req, mem_we, stall_fetch, stall_data;
  logic [31:0] if_rdata, mem_addr, mem_wdata;
  logic [7:0]  d_rdata;
  logic [3:0]  mem_be;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic        is_fetch;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        is_fetch;
    logic        we;
    logic [31:0] addr;
    logic [7:0]  wdata;
    logic [31:0] rdata;
    int          delay;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rd;
  } vec_t;
  vec_t vecs[8];

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
    .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_fetch(stall_fetch), .stall_data(stall_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Every ready pulse must match the oldest outstanding expected completion.
  always @(negedge clk) begin
    if (if_ready === 1'b1) begin
      if (sb.size() == 0) chk("unexpected if_ready", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb kind (fetch)", {31'd0, e.is_fetch}, 32'd1);
        chk("sb if_rdata", if_rdata, e.data);
      end
    end
    if (d_ready === 1'b1) begin
      if (sb.size() == 0) chk("unexpected d_ready", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb kind (data)", {31'd0, e.is_fetch}, 32'd0);
        chk("sb d_rdata", {24'd0, d_rdata}, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic run_vec(input vec_t v, input int idx);
    if (v.is_fetch) begin
      if_req = 1'b1; if_addr = v.addr;
    end else begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end
    sb.push_back('{v.is_fetch, v.e_rd});
    @(posedge clk); #1;
    chk($sformatf("v%0d mem_req", idx), {31'd0, mem_req}, 32'd1);
    chk($sformatf("v%0d mem_addr", idx), mem_addr, v.e_addr);
    chk($sformatf("v%0d mem_be", idx), {28'd0, mem_be}, {28'd0, v.e_be});
    chk($sformatf("v%0d mem_we", idx), {31'd0, mem_we}, {31'd0, v.is_fetch ? 1'b0 : v.we});
    if (!v.is_fetch) chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.e_wdata);
    chk($sformatf("v%0d stall", idx), {31'd0, v.is_fetch ? stall_fetch : stall_data}, 32'd1);
    for (int i = 0; i < v.delay; i++) begin
      @(posedge clk); #1;
      chk($sformatf("v%0d mem_req hold", idx), {31'd0, mem_req}, 32'd1);
      chk($sformatf("v%0d mem_addr hold", idx), mem_addr, v.e_addr);
    end
    mem_ready = 1'b1; mem_rdata = v.rdata;
    @(posedge clk); #1;
    mem_ready = 1'b0; mem_rdata = 32'h0BAD0BAD;
    chk($sformatf("v%0d ready pulse", idx), {31'd0, v.is_fetch ? if_ready : d_ready}, 32'd1);
    chk($sformatf("v%0d stall release", idx), {31'd0, v.is_fetch ? stall_fetch : stall_data}, 32'd0);
    chk($sformatf("v%0d mem_req drop", idx), {31'd0, mem_req}, 32'd0);
    if_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("v%0d ready one cycle", idx), {31'd0, v.is_fetch ? if_ready : d_ready}, 32'd0);
    chk($sformatf("v%0d no regrant", idx), {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0102, 8'h00, 32'hA5A5_1234, 0, 32'h0000_0100, 4'hF, 32'h0, 32'hA5A5_1234};
    vecs[1] = '{1'b0, 1'b0, 32'h0000_0043, 8'h00, 32'h1122_3344, 0, 32'h0000_0040, 4'b1000, 32'h0, 32'h11};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_0041, 8'h7E, 32'hFFFF_FFFF, 2, 32'h0000_0040, 4'b0010, 32'h7E7E_7E7E, 32'h11};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_1000, 8'h00, 32'hDEAD_BEEF, 1, 32'h0000_1000, 4'b0001, 32'h0, 32'hEF};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_1001, 8'h00, 32'hDEAD_BEEF, 0, 32'h0000_1000, 4'b0010, 32'h0, 32'hBE};
    vecs[5] = '{1'b0, 1'b0, 32'hFFFF_FFFE, 8'h00, 32'h0102_0304, 0, 32'hFFFF_FFFC, 4'b0100, 32'h0, 32'h02};
    vecs[6] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 8'h00, 32'h89AB_CDEF, 1, 32'hFFFF_FFFC, 4'hF, 32'h0, 32'h89AB_CDEF};
    vecs[7] = '{1'b0, 1'b1, 32'h0000_0003, 8'h80, 32'h0000_0000, 0, 32'h0000_0000, 4'b1000, 32'h8080_8080, 32'h02};

    reset = 1'b1; if_req = 0; if_cancel = 0; d_req = 0; d_we = 0; mem_ready = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    #2;
    chk("reset mem_req", {31'd0, mem_req}, 32'd0);
    chk("reset mem_we", {31'd0, mem_we}, 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset mem_be", {28'd0, mem_be}, 32'd0);
    chk("reset if_ready", {31'd0, if_ready}, 32'd0);
    chk("reset if_rdata", if_rdata, 32'd0);
    chk("reset d_ready", {31'd0, d_ready}, 32'd0);
    chk("reset d_rdata", {24'd0, d_rdata}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Cancelled fetch: memory still completes, but no if_ready, then a load is granted right away.
    if_req = 1'b1; if_addr = 32'h0000_0300;
    @(posedge clk); #1;
    chk("cancel mem_req", {31'd0, mem_req}, 32'd1);
    chk("cancel mem_be", {28'd0, mem_be}, 32'hF);
    if_cancel = 1'b1; #1;
    chk("cancel stall_fetch", {31'd0, stall_fetch}, 32'd0);
    @(posedge clk); #1;
    if_cancel = 1'b0; if_req = 1'b0;
    @(posedge clk); #1;
    chk("cancel mem_req hold", {31'd0, mem_req}, 32'd1);
    @(posedge clk); #1;
    mem_ready = 1'b1; mem_rdata = 32'h5555_5555;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0002;
    sb.push_back('{1'b0, 32'hAA});
    @(posedge clk); #1;
    mem_ready = 1'b0;
    chk("cancel no if_ready", {31'd0, if_ready}, 32'd0);
    chk("cancel if_rdata kept", if_rdata, 32'h89AB_CDEF);
    chk("cancel mem_req drop", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;
    chk("post-cancel load grant", {31'd0, mem_req}, 32'd1);
    chk("post-cancel load be", {28'd0, mem_be}, 32'b0100);
    mem_ready = 1'b1; mem_rdata = 32'h00AA_0000;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    chk("post-cancel d_ready", {31'd0, d_ready}, 32'd1);
    d_req = 1'b0;
    @(posedge clk); #1;

    // Both requesting continuously: four data grants, then one fetch, repeating.
    if_req = 1'b1; if_addr = 32'h0000_0200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0;
    mem_rdata = 32'hCAFE_BABE;
    for (int k = 0; k < 10; k++) sb.push_back((k % 5 == 4) ? '{1'b1, 32'hCAFE_BABE} : '{1'b0, 32'hBE});
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk($sformatf("starve grant %0d be", k), {28'd0, mem_be}, (k % 5 == 4) ? 32'hF : 32'h1);
      if (k == 0) chk("starve stall_fetch", {31'd0, stall_fetch}, 32'd1);
      if (k == 4) chk("starve fetch addr", mem_addr, 32'h0000_0200);
      mem_ready = 1'b1;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      if (k == 9) begin if_req = 1'b0; d_req = 1'b0; end
    end
    @(posedge clk); #1;
    chk("starve end idle", {31'd0, mem_req}, 32'd0);

    // mem_ready while idle must be ignored.
    mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    chk("idle mem_ready if_ready", {31'd0, if_ready}, 32'd0);
    chk("idle mem_ready d_ready", {31'd0, d_ready}, 32'd0);
    chk("idle mem_ready d_rdata", {24'd0, d_rdata}, 32'hBE);

    // Reset in the middle of a fetch.
    if_req = 1'b1; if_addr = 32'h0000_0400;
    @(posedge clk); #1;
    chk("rst-mid mem_req before", {31'd0, mem_req}, 32'd1);
    #3 reset = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    #1;
    chk("rst-mid mem_req same cycle", {31'd0, mem_req}, 32'd0);
    chk("rst-mid if_rdata cleared", if_rdata, 32'd0);
    if_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("rst-mid idle %0d mem_req", i), {31'd0, mem_req}, 32'd0);
      chk($sformatf("rst-mid idle %0d ready", i), {30'd0, if_ready, d_ready}, 32'd0);
    end

    chk("scoreboard drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
